// File: rtl/cache_cell_selector.sv
// Cell selector for small fully-associative caches: masks tag matches
// with tracked valid bits, resolves a hit or picks a victim, emits enables.
module cache_cell_selector #(
  parameter int CELL_CNT  = 4,
  parameter int REPL_MODE = 0,
  localparam int IDXW = $clog2(CELL_CNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  input  logic [CELL_CNT-1:0] cmp_results,
  output logic                lookup_ready,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [IDXW-1:0]     resp_idx,
  output logic [CELL_CNT-1:0] resp_enables,
  input  logic                fill_done,
  input  logic                inval_all,
  output logic [CELL_CNT-1:0] valid_bits
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_ALLOC
  } state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(CELL_CNT - 1);

  state_t state_q, state_d;

  logic [CELL_CNT-1:0] valid_q, valid_d;
  logic [CELL_CNT-1:0] match, en_c;
  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [IDXW-1:0]     hit_idx, inv_idx;
  logic [IDXW-1:0]     plru_vic, victim, sel_idx;
  logic [CELL_CNT-1:1] plru_q, plru_d;
  logic                hit_c, inv_any;
  logic                from_ptr_q;
  logic                accept, hit_upd, fill_upd;

  assign match        = cmp_results & valid_q;
  assign hit_c        = |match;
  assign inv_any      = ~&valid_q;
  assign lookup_ready = (state_q == S_IDLE);
  assign valid_bits   = valid_q;

  // highest matching cell wins; lowest invalid cell is preferred victim
  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    for (int i = 0; i < CELL_CNT; i++)
      if (match[i]) hit_idx = IDXW'(i);
    for (int i = CELL_CNT - 1; i >= 0; i--)
      if (!valid_q[i]) inv_idx = IDXW'(i);
  end

  // heap-ordered tree, node 1 is the root
  always_comb begin : plru_walk
    int n;
    n = 1;
    for (int l = 0; l < IDXW; l++)
      n = 2 * n + int'(plru_q[n]);
    plru_vic = IDXW'(n - CELL_CNT);
  end

  always_comb begin
    victim = ptr_q;
    if (REPL_MODE == 0)
      victim = LAST;
    else if (inv_any)
      victim = inv_idx;
    else if (REPL_MODE == 2)
      victim = plru_vic;

    sel_idx = hit_c ? hit_idx : victim;

    en_c = '0;
    if (REPL_MODE == 0) begin
      for (int i = 0; i < CELL_CNT; i++)
        en_c[i] = !hit_c || (i <= int'(hit_idx));
    end else begin
      en_c[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    hit_upd  = 1'b0;
    fill_upd = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lookup_valid) begin
          accept  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_hit) begin
          hit_upd = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        if (fill_done) begin
          fill_upd = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : upd
    int n;
    n       = 1;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    plru_d  = plru_q;

    if (hit_upd && REPL_MODE == 0) begin
      for (int i = 1; i < CELL_CNT; i++)
        if (i <= int'(resp_idx)) valid_d[i] = valid_q[i-1];
      valid_d[0] = 1'b1;
    end

    if (fill_upd) begin
      if (REPL_MODE == 0)
        valid_d = {valid_q[CELL_CNT-2:0], 1'b1};
      else
        valid_d[resp_idx] = 1'b1;
      if (REPL_MODE == 1 && from_ptr_q)
        ptr_d = ptr_q + IDXW'(1);
    end

    // point every node on the path away from the touched cell
    if ((hit_upd || fill_upd) && REPL_MODE == 2) begin
      for (int l = IDXW - 1; l >= 0; l--) begin
        plru_d[n] = ~resp_idx[l];
        n = 2 * n + int'(resp_idx[l]);
      end
    end

    if (inval_all) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      ptr_q        <= '0;
      plru_q       <= '0;
      from_ptr_q   <= 1'b0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_idx     <= '0;
      resp_enables <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      plru_q     <= plru_d;
      resp_valid <= accept;
      if (accept) begin
        resp_hit     <= hit_c;
        resp_idx     <= sel_idx;
        resp_enables <= en_c;
        from_ptr_q   <= !inv_any;
      end
    end
  end

endmodule
